// File: rtl/hls_run_controller.sv
// Host-command sequencer for a Bambu `main` accelerator. It preloads and reads back slave memory and times start->done runs.
// Optional run watchdog with TIMEOUT response and DRAIN window: define HLS_RUN_CTRL_TIMEOUT_EN.
module hls_run_controller #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int SIZE_W     = 4,
  parameter int MAX_CYCLES = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_status,
  output logic [31:0]           rsp_data,
  output logic                  start_port,
  input  logic                  done_port,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SACC  = 3'd1,
    RUN   = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_RUN     = 2'b10;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADOP   = 2'b10;

`ifdef HLS_RUN_CTRL_TIMEOUT_EN
  localparam logic LP_TO_EN = 1'b1;
`else
  localparam logic LP_TO_EN = 1'b0;
`endif

  localparam logic [31:0] LP_MAX = 32'(MAX_CYCLES);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdat;
  logic [31:0]         r_cnt;
  logic [1:0]          r_rsp_status;
  logic [31:0]         r_rsp_data;
  logic                r_start;
  logic                r_timed_out;
  logic [3:0]          r_drain_cnt;

  logic                w_acc_done;
  logic                w_limit;
  logic                w_unused;

  assign w_acc_done = Sout_DataRdy[0];
  // Watchdog compare is constant-false unless the timeout feature is built in.
  assign w_limit    = LP_TO_EN && (r_cnt == LP_MAX);
  assign w_unused   = ^{Sout_DataRdy[1], Sout_Rdata_ram[2*DATA_W-1:DATA_W]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_status      = 2'b00;
    rsp_data        = 32'd0;
    start_port      = 1'b0;
    S_oe_ram        = 2'b00;
    S_we_ram        = 2'b00;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;

    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE, OP_READ: w_next = SACC;
            OP_RUN:            w_next = RUN;
            default:           w_next = RESP;
          endcase
        end
      end

      SACC: begin
        S_we_ram[0]     = (r_op == OP_WRITE);
        S_oe_ram[0]     = (r_op == OP_READ);
        S_addr_ram      = {{ADDR_W{1'b0}}, r_addr};
        S_Wdata_ram     = {{DATA_W{1'b0}}, (r_op == OP_WRITE) ? r_wdat : {DATA_W{1'b0}}};
        S_data_ram_size = {{SIZE_W{1'b0}}, SIZE_W'(8)};
        if (w_acc_done) begin
          w_next = RESP;
        end
      end

      RUN: begin
        start_port = r_start;
        if (done_port || w_limit) begin
          w_next = RESP;
        end
      end

      RESP: begin
        rsp_valid  = 1'b1;
        rsp_status = r_rsp_status;
        rsp_data   = r_rsp_data;
        if (rsp_ready) begin
          w_next = r_timed_out ? DRAIN : IDLE;
        end
      end

      DRAIN: begin
        // Swallow the late done of a timed-out run so the next RUN starts clean.
        if (done_port || (r_drain_cnt == 4'hF)) begin
          w_next = IDLE;
        end
      end

      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op         <= 2'b00;
      r_addr       <= '0;
      r_wdat       <= '0;
      r_cnt        <= 32'd0;
      r_rsp_status <= 2'b00;
      r_rsp_data   <= 32'd0;
      r_start      <= 1'b0;
      r_timed_out  <= 1'b0;
      r_drain_cnt  <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op        <= cmd_op;
            r_addr      <= cmd_addr;
            r_wdat      <= cmd_data;
            r_timed_out <= 1'b0;
            if (cmd_op == OP_RUN) begin
              r_start <= 1'b1;
              r_cnt   <= 32'd1;
            end else if (cmd_op != OP_WRITE && cmd_op != OP_READ) begin
              r_rsp_status <= ST_BADOP;
              r_rsp_data   <= 32'd0;
            end
          end
        end

        SACC: begin
          if (w_acc_done) begin
            r_rsp_status <= ST_OK;
            r_rsp_data   <= (r_op == OP_READ)
                            ? {{(32-DATA_W){1'b0}}, Sout_Rdata_ram[DATA_W-1:0]}
                            : 32'd0;
          end
        end

        RUN: begin
          r_start <= 1'b0;
          if (r_cnt != 32'hFFFF_FFFF) begin
            r_cnt <= r_cnt + 32'd1;
          end
          if (done_port) begin
            r_rsp_status <= ST_OK;
            r_rsp_data   <= r_cnt;
          end else if (w_limit) begin
            r_rsp_status <= ST_TIMEOUT;
            r_rsp_data   <= LP_MAX;
            r_timed_out  <= 1'b1;
          end
        end

        RESP: begin
          r_drain_cnt <= 4'd0;
        end

        DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 4'd1;
        end

        default: begin
          r_drain_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hls_run_controller.sv
// Directed bench for hls_run_controller with a 2-cycle slave memory model and a hand-driven done_port.
module tb_hls_run_controller;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic        start_port;
  logic        done_port;
  logic [1:0]  S_oe_ram;
  logic [1:0]  S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;

  int checks   = 0;
  int failures = 0;
  int start_seen = 0;

  logic [7:0] mem [0:127];
  int         lat;
  logic       acc;

  hls_run_controller #(
    .ADDR_W(7), .DATA_W(8), .SIZE_W(4), .MAX_CYCLES(100)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .start_port(start_port), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  always #5 clock = ~clock;

  // Slave model: completes an access in the third cycle the strobe is held.
  assign acc            = S_oe_ram[0] | S_we_ram[0];
  assign Sout_DataRdy   = {1'b0, acc && (lat == 2)};
  assign Sout_Rdata_ram = {8'hEE, mem[S_addr_ram[6:0]]};

  always @(posedge clock or negedge reset) begin
    if (!reset) lat <= 0;
    else if (acc && !Sout_DataRdy[0]) lat <= lat + 1;
    else lat <= 0;
  end

  always @(posedge clock) begin
    if (reset && S_we_ram[0] && Sout_DataRdy[0]) mem[S_addr_ram[6:0]] <= S_Wdata_ram[7:0];
    if (reset && start_port) start_seen <= start_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [6:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (!rsp_valid && n < budget) begin
      tick();
      n++;
    end
    check("rsp_within_budget", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic wr_rd_pair();
    int n;
    cmd(2'b00, 7'h05, 8'hA7);
    check("wr_we",   {30'd0, S_we_ram}, 32'h1);
    check("wr_oe",   {30'd0, S_oe_ram}, 32'h0);
    check("wr_addr", {18'd0, S_addr_ram}, 32'h0005);
    check("wr_data", {16'd0, S_Wdata_ram}, 32'h00A7);
    check("wr_size", {24'd0, S_data_ram_size}, 32'h08);
    wait_rsp(20, n);
    check("wr_status", {30'd0, rsp_status}, 32'd0);
    check("wr_rsp_data", rsp_data, 32'd0);
    tick();
    check("wr_rsp_1cycle", {31'd0, rsp_valid}, 32'd0);
    check("wr_strobe_off", {28'd0, S_we_ram, S_oe_ram}, 32'd0);
    cmd(2'b01, 7'h05, 8'h00);
    check("rd_oe",   {30'd0, S_oe_ram}, 32'h1);
    check("rd_we",   {30'd0, S_we_ram}, 32'h0);
    check("rd_size", {24'd0, S_data_ram_size}, 32'h08);
    wait_rsp(20, n);
    check("rd_latency", n + 1, 32'd4);
    check("rd_status", {30'd0, rsp_status}, 32'd0);
    check("rd_rsp_data", rsp_data, 32'h0000_00A7);
    tick();
    check("rd_rsp_1cycle", {31'd0, rsp_valid}, 32'd0);
    check("rd_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_case(input int delay, input logic [31:0] exp);
    start_seen = 0;
    cmd(2'b10, 7'h00, 8'h00);
    check("run_start_high", {31'd0, start_port}, 32'd1);
    check("run_no_strobe", {28'd0, S_we_ram, S_oe_ram}, 32'd0);
    repeat (delay) tick();
    done_port = 1'b1;
    tick();
    done_port = 1'b0;
    check("run_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("run_status", {30'd0, rsp_status}, 32'd0);
    check("run_count", rsp_data, exp);
    check("run_start_once", start_seen, 32'd1);
    tick();
    check("run_rsp_1cycle", {31'd0, rsp_valid}, 32'd0);
    check("run_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    clock     = 1'b0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 7'h00;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;
    done_port = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    repeat (2) @(posedge clock);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_outputs", {28'd0, rsp_valid, start_port, |S_we_ram, |S_oe_ram}, 32'd0);
    check("rst_size_addr", {10'd0, S_addr_ram, S_data_ram_size}, 32'd0);
    reset = 1'b1;
    tick();

    wr_rd_pair();
    run_case(37, 32'd38);
    run_case(0, 32'd1);

    // Reserved opcode with the host stalling the response.
    rsp_ready = 1'b0;
    start_seen = 0;
    cmd(2'b11, 7'h12, 8'h34);
    for (int i = 0; i < 6; i++) begin
      check("bad_valid", {31'd0, rsp_valid}, 32'd1);
      check("bad_status", {30'd0, rsp_status}, 32'h2);
      check("bad_data", rsp_data, 32'd0);
      check("bad_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bad_no_drive", {28'd0, S_we_ram, S_oe_ram}, 32'd0);
      tick();
    end
    check("bad_no_start", start_seen, 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("bad_released", {30'd0, rsp_valid, cmd_ready}, 32'h1);

    // Reset in the middle of a RUN.
    cmd(2'b10, 7'h00, 8'h00);
    tick();
    check("mid_run_busy", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_run_start", {31'd0, start_port}, 32'd0);
    check("rst_run_rsp", {31'd0, rsp_valid}, 32'd0);
    #2;
    reset = 1'b1;
    tick();
    check("rst_run_idle", {31'd0, cmd_ready}, 32'd1);

    // Reset in the middle of a slave access.
    cmd(2'b00, 7'h05, 8'h3C);
    check("mid_sacc_we", {30'd0, S_we_ram}, 32'h1);
    reset = 1'b0;
    #1;
    check("rst_sacc_strobe", {28'd0, S_we_ram, S_oe_ram}, 32'd0);
    check("rst_sacc_size", {24'd0, S_data_ram_size}, 32'd0);
    #2;
    reset = 1'b1;
    tick();
    check("rst_sacc_idle", {30'd0, cmd_ready, rsp_valid}, 32'h2);
    wr_rd_pair();

`ifdef HLS_RUN_CTRL_TIMEOUT_EN
    begin
      int n;
      cmd(2'b10, 7'h00, 8'h00);
      wait_rsp(150, n);
      check("to_status", {30'd0, rsp_status}, 32'h1);
      check("to_data", rsp_data, 32'd100);
      check("to_latency", n, 32'd100);
      tick();
      check("to_drain_busy", {30'd0, rsp_valid, cmd_ready}, 32'd0);
      repeat (4) tick();
      done_port = 1'b1;
      tick();
      done_port = 1'b0;
      check("to_drain_exit", {30'd0, rsp_valid, cmd_ready}, 32'h1);
      run_case(9, 32'd10);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
